// File: rtl/inst_encoder_pkg.sv
// Shared RV32I encoder definitions: instruction formats, NOP word and the
// major opcodes common with the core decoder.
package inst_encoder_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;

endpackage

// File: rtl/inst_encoder_imm_pack.sv
// Combinational packer: scatters fields and immediate into the RV32I layout
// selected by fmt and flags immediates that do not fit that layout.
module inst_encoder_imm_pack
  import inst_encoder_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] inst,
  output logic        err
);

  fmt_t        fmt_s;
  logic [31:0] raw_s;
  logic        bad_s;

  assign fmt_s = fmt_t'(fmt);

  // Format-specific packing; "bad" means the immediate is out of range or misaligned.
  always_comb begin
    raw_s = NOP_INST;
    bad_s = 1'b1;
    case (fmt_s)
      FMT_R: begin
        raw_s = {funct7, rs2, rs1, funct3, rd, opcode};
        bad_s = 1'b0;
      end
      FMT_I: begin
        raw_s = {imm[11:0], rs1, funct3, rd, opcode};
        bad_s = (imm[31:11] != {21{imm[11]}});
      end
      FMT_S: begin
        raw_s = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        bad_s = (imm[31:11] != {21{imm[11]}});
      end
      FMT_B: begin
        raw_s = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        bad_s = (imm[31:12] != {20{imm[12]}}) || imm[0];
      end
      FMT_U: begin
        raw_s = {imm[31:12], rd, opcode};
        bad_s = (imm[11:0] != 12'd0);
      end
      FMT_J: begin
        raw_s = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        bad_s = (imm[31:20] != {12{imm[20]}}) || imm[0];
      end
      default: begin
        raw_s = NOP_INST;
        bad_s = 1'b1;
      end
    endcase
  end

  // Rejected inputs are replaced by the canonical NOP.
  always_comb begin
    err = bad_s || (opcode[1:0] != 2'b11);
    if (err) begin
      inst = NOP_INST;
    end else begin
      inst = raw_s;
    end
  end

endmodule

// File: rtl/inst_encoder.sv
// RV32I instruction encoder with a single-entry valid/ready output stage,
// sequential write address and saturating reject counter.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [7:0]        err_count
);

  logic [31:0]       pack_inst_s;
  logic              pack_err_s;
  logic              accept_s;
  logic              xfer_s;
  logic              out_valid_r;
  logic [31:0]       out_inst_r;
  logic              out_err_r;
  logic [ADDR_W-1:0] addr_r;
  logic [7:0]        err_count_r;

  inst_encoder_imm_pack u_imm_pack (
    .fmt    (fmt),
    .opcode (opcode),
    .rd     (rd),
    .rs1    (rs1),
    .rs2    (rs2),
    .funct3 (funct3),
    .funct7 (funct7),
    .imm    (imm),
    .inst   (pack_inst_s),
    .err    (pack_err_s)
  );

  assign in_ready = !clear && (!out_valid_r || out_ready);
  assign accept_s = in_valid && in_ready;
  assign xfer_s   = out_valid_r && out_ready;

  // Output holding register; a pending word is dropped by clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_inst_r  <= 32'd0;
      out_err_r   <= 1'b0;
    end else if (clear) begin
      out_valid_r <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_inst_r  <= pack_inst_s;
      out_err_r   <= pack_err_s;
    end else if (xfer_s) begin
      out_valid_r <= 1'b0;
    end
  end

  // Write address advances once per delivered word and wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r <= '0;
    end else if (clear) begin
      addr_r <= '0;
    end else if (xfer_s) begin
      addr_r <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  end

  // Reject counter counts at accept time and sticks at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_r <= 8'd0;
    end else if (clear) begin
      err_count_r <= 8'd0;
    end else if (accept_s && pack_err_s && (err_count_r != 8'hFF)) begin
      err_count_r <= err_count_r + 8'd1;
    end
  end

  assign out_valid = out_valid_r;
  assign out_inst  = out_inst_r;
  assign out_err   = out_err_r;
  assign out_addr  = addr_r;
  assign err_count = err_count_r;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder with hand-computed encodings, backpressure,
// address wrap, counter saturation, clear/reset and an immediate round trip.
module tb_inst_encoder;

  localparam int AW = 2;

  logic          clk;
  logic          rst_n;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    fmt;
  logic [6:0]    opcode;
  logic [4:0]    rd, rs1, rs2;
  logic [2:0]    funct3;
  logic [6:0]    funct7;
  logic [31:0]   imm;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_inst;
  logic [AW-1:0] out_addr;
  logic          out_err;
  logic [7:0]    err_count;

  int checks = 0;
  int errors = 0;

  inst_encoder #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fmt       (fmt),
    .opcode    (opcode),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .funct7    (funct7),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_addr  (out_addr),
    .out_err   (out_err),
    .err_count (err_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_fields(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                            input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] im);
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
  endtask

  // Present one input and hold it until accepted (bounded); returns at accept edge + 1.
  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] im, output int waits);
    set_fields(f, op, d, s1, s2, f3, f7, im);
    in_valid = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    check("accept_wait", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Reference immediate generator of the core decoder.
  function automatic logic [31:0] dec_imm(input logic [2:0] f, input logic [31:0] i);
    case (f)
      3'd1:    dec_imm = {{20{i[31]}}, i[31:20]};
      3'd2:    dec_imm = {{20{i[31]}}, i[31:25], i[11:7]};
      3'd3:    dec_imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd4:    dec_imm = {i[31:12], 12'd0};
      3'd5:    dec_imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: dec_imm = 32'd0;
    endcase
  endfunction

  initial begin
    int w;
    logic [31:0] r;
    logic [31:0] rimm;
    logic [2:0]  rf;
    logic [6:0]  rop;
    logic [AW-1:0] exp_addr;

    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_fields(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_addr", 32'(out_addr), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // I-type addi x5, x6, -1
    send(3'd1, 7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, w);
    check("i_inst", out_inst, 32'hFFF3_0293);
    check("i_err", 32'(out_err), 32'd0);
    check("i_addr", 32'(out_addr), 32'd0);
    check("i_valid", 32'(out_valid), 32'd1);

    // B-type legal then misaligned
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8, w);
    check("b_inst", out_inst, 32'h0020_8463);
    check("b_addr", 32'(out_addr), 32'd1);
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, w);
    check("b_bad_inst", out_inst, 32'h0000_0013);
    check("b_bad_err", 32'(out_err), 32'd1);
    check("b_bad_cnt", 32'(err_count), 32'd1);
    check("b_bad_addr", 32'(out_addr), 32'd2);

    // clear, with in_ready forced low during the clear cycle
    clear = 1'b1;
    @(negedge clk);
    check("clr_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    clear = 1'b0;
    check("clr_valid", 32'(out_valid), 32'd0);
    check("clr_addr", 32'(out_addr), 32'd0);
    check("clr_cnt", 32'(err_count), 32'd0);

    // U/J back-to-back
    send(3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, w);
    check("lui_inst", out_inst, 32'h1234_50B7);
    check("lui_addr", 32'(out_addr), 32'd0);
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, w);
    check("jal_b2b", 32'(w), 32'd0);
    check("jal_inst", out_inst, 32'h0010_00EF);
    check("jal_addr", 32'(out_addr), 32'd1);
    @(posedge clk); #1;
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_addr", 32'(out_addr), 32'd2);

    // Backpressure: first word held, second waits
    out_ready = 1'b0;
    send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, w);
    set_fields(3'd2, 7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'hFFFF_FFFC);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_inst", out_inst, 32'h0020_81B3);
      check("bp_addr", 32'(out_addr), 32'd2);
      check("bp_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp2_inst", out_inst, 32'hFE51_2E23);
    check("bp2_addr", 32'(out_addr), 32'd3);
    check("bp2_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    check("wrap_addr", 32'(out_addr), 32'd0);
    check("wrap_valid", 32'(out_valid), 32'd0);

    // Round trip of random legal immediates through the reference decoder
    exp_addr = '0;
    for (int k = 0; k < 20; k++) begin
      r  = $urandom;
      rf = 3'((k % 5) + 1);
      case (rf)
        3'd1: begin rimm = {{20{r[11]}}, r[11:0]};        rop = 7'h13; end
        3'd2: begin rimm = {{20{r[11]}}, r[11:0]};        rop = 7'h23; end
        3'd3: begin rimm = {{19{r[12]}}, r[12:1], 1'b0};  rop = 7'h63; end
        3'd4: begin rimm = {r[31:12], 12'd0};             rop = 7'h37; end
        default: begin rimm = {{11{r[20]}}, r[20:1], 1'b0}; rop = 7'h6F; end
      endcase
      send(rf, rop, 5'(r[4:0]), 5'(r[9:5]), 5'(r[14:10]), 3'(r[17:15]), 7'd0, rimm, w);
      check("rt_imm", dec_imm(rf, out_inst), rimm);
      check("rt_op", 32'(out_inst[6:0]), 32'(rop));
      check("rt_err", 32'(out_err), 32'd0);
      check("rt_addr", 32'(out_addr), 32'(exp_addr));
      exp_addr = exp_addr + 2'd1;
    end

    // Boundary cases
    send(3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800, w);
    check("i_min_inst", out_inst, 32'h8000_0013);
    check("i_min_err", 32'(out_err), 32'd0);
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, w);
    check("i_over_err", 32'(out_err), 32'd1);
    send(3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0001, w);
    check("u_low_err", 32'(out_err), 32'd1);
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0003, w);
    check("j_odd_err", 32'(out_err), 32'd1);
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0000_1000, w);
    check("b_over_err", 32'(out_err), 32'd1);
    send(3'd0, 7'h30, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, w);
    check("op_low_err", 32'(out_err), 32'd1);
    check("op_low_inst", out_inst, 32'h0000_0013);
    send(3'd7, 7'h33, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, w);
    check("fmt7_err", 32'(out_err), 32'd1);
    check("bnd_cnt", 32'(err_count), 32'd6);

    // Saturation
    for (int k = 0; k < 300; k++) begin
      send(3'd6, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, w);
    end
    check("sat_cnt", 32'(err_count), 32'd255);
    check("sat_err", 32'(out_err), 32'd1);

    // clear drops a pending word and blocks a concurrent input
    out_ready = 1'b0;
    set_fields(3'd1, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd1);
    in_valid = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    check("clr2_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    clear = 1'b0;
    in_valid = 1'b0;
    check("clr2_valid", 32'(out_valid), 32'd0);
    check("clr2_addr", 32'(out_addr), 32'd0);
    check("clr2_cnt", 32'(err_count), 32'd0);
    @(posedge clk); #1;
    check("clr2_no_accept", 32'(out_valid), 32'd0);

    // Asynchronous reset while a word is held
    send(3'd1, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd1, w);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_inst", out_inst, 32'd0);
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Streaming RISC-V RV32I instruction encoder: the inverse of the core's immediate decoder. It accepts decoded fields plus a full 32-bit immediate and packs them into a 32-bit instruction word in the R/I/S/B/U/J layout. It range-checks and alignment-checks the immediate, and presents the word with a sequential write address for loading instruction memory. It sits in the debug/program-loader path ahead of instruction memory, behind a valid/ready source.

## Interface
Parameters:
- ADDR_W, 10, width of the instruction-memory word address.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous restart: address and error count to 0.
- in_valid  in  1  input fields valid.
- in_ready  out  1  encoder accepts input this cycle.
- fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
- opcode  in  7  inst[6:0].
- rd, rs1, rs2  in  5 each  register fields.
- funct3  in  3  inst[14:12].
- funct7  in  7  inst[31:25]; used for R only.
- imm  in  32  full signed/unsigned immediate value; ignored for R.
- out_valid  out  1  out_inst/out_addr/out_err valid.
- out_ready  in  1  sink accepts output.
- out_inst  out  32  encoded word.
- out_addr  out  ADDR_W  word address for out_inst.
- out_err  out  1  input was rejected; out_inst is the NOP.
- err_count  out  8  saturating count of rejected inputs.

## Operation
- Single output register with valid/ready handshake. in_ready = !out_valid || out_ready; combinational, no dependence on in_valid.
- Accept = in_valid && in_ready. On accept, the register loads the encoded word and error flag, and out_valid goes to 1.
- Transfer = out_valid && out_ready. Transfer with no accept clears out_valid. Accept and transfer in the same cycle keeps out_valid at 1 and replaces the contents.
- Encoding per fmt (only fields used by the format are packed; unused fields are ignored):
  - R: funct7|rs2|rs1|funct3|rd|opcode.
  - I: imm[11:0]|rs1|funct3|rd|opcode.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
  - U: imm[31:12]|rd|opcode.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
- Legality checks (any failure causes an error):
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - U: imm[11:0]=0.
  - fmt 6 or 7 is illegal.
  - opcode[1:0] must be 2'b11 for every format.
- On error: out_inst = 32'h0000_0013 (addi x0,x0,0), out_err = 1, and err_count increments, saturating at 255. The counter increments at accept, not at transfer.
- out_addr: a counter that increments by 1 after each transfer and wraps from 2^ADDR_W-1 to 0. Error words consume an address like any other word.
- clear (priority over everything):
  - next cycle: out_valid=0, addr=0, err_count=0.
  - in_ready is forced to 0 during the clear cycle, so no accept occurs.
  - a pending output is dropped.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 word/cycle when out_ready is held high.
- While out_valid=1 && out_ready=0: out_inst, out_addr and out_err are held stable, and in_ready=0.
- Reset values: out_valid=0, out_inst=0, out_addr=0, out_err=0, err_count=0.
- Reset asserted mid-transfer discards the held word immediately; no partial state survives.

## Structure
- Shared package:
  - FMT_R..FMT_J constants and the 3-bit fmt type.
  - NOP_INST = 32'h0000_0013.
  - opcode constants shared with the core decoder.
- Sub-module imm_pack: purely combinational; takes fmt/fields/imm and returns {inst, err}. The top level holds the handshake register, address counter and error counter.

## Test plan
- I-type: fmt=I, opcode=7'h13, rd=5, rs1=6, funct3=0, imm=32'hFFFF_FFFF -> out_inst=32'hFFF3_0293, out_err=0, out_addr=0.
- B-type: fmt=B, opcode=7'h63, rs1=1, rs2=2, imm=8 -> 32'h0020_8463. Then imm=3 -> out_inst=32'h0000_0013, out_err=1, err_count=1.
- U/J pair back-to-back with out_ready=1:
  - lui rd=1, imm=32'h1234_5000 -> 32'h1234_50B7 at addr 0.
  - jal rd=1, imm=32'h800 -> 32'h0010_00EF at addr 1.
  - Both accepted on consecutive cycles.
- Backpressure: out_ready=0, feed two inputs -> first held stable, in_ready=0 until out_ready=1, then second accepted the same cycle; no word lost or duplicated.
- Wrap and saturation:
  - ADDR_W=2, 5 transfers -> addresses 0,1,2,3,0.
  - 300 illegal inputs -> err_count=255.
  - clear -> addr=0, err_count=0, out_valid=0.
- Round trip: random legal fields/imm per format -> decoding out_inst with the core immediate generator returns the sign-extended imm exactly.
